// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
//   Shares a single memory-bridge port between the icache (reads only) and
//   the dcache (reads and writes).
//   - Read path: one outstanding read burst at a time. The winner of the
//     icache/dcache arbitration has its request latched and forwarded to the
//     bridge. Return beats are steered to the owner with no added latency.
//   - Write path: one dcache write (a full line or a single word) is buffered
//     and then sent to the bridge as 32-bit beats. The read and write paths
//     run concurrently.
//   - A dcache read whose line is still in the write buffer is held off
//     (read-after-write hazard). The icache may be granted in the meantime.
//
// Ports
//   clk, resetn                         clock, asynchronous active-low reset
//   ic_rd_* / ic_ret_*                  icache read request and return beats
//   dc_rd_* / dc_ret_*                  dcache read request and return beats
//   dc_wr_*                             dcache write request (line or word)
//   mem_rd_* / mem_ret_*                read request to and return from bridge
//   mem_wr_*                            write beats to bridge, burst response
//
// Parameters
//   RR_EN       1: round-robin on read ties; 0: dcache always wins a tie
//   LINE_WORDS  32-bit words per cache line (128-bit line => 4)
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter bit RR_EN      = 1'b1,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         resetn,

    input  logic         ic_rd_req,
    input  logic [2:0]   ic_rd_type,
    input  logic [31:0]  ic_rd_addr,
    output logic         ic_rd_rdy,
    output logic         ic_ret_valid,
    output logic [1:0]   ic_ret_last,
    output logic [31:0]  ic_ret_data,

    input  logic         dc_rd_req,
    input  logic [2:0]   dc_rd_type,
    input  logic [31:0]  dc_rd_addr,
    output logic         dc_rd_rdy,
    output logic         dc_ret_valid,
    output logic [1:0]   dc_ret_last,
    output logic [31:0]  dc_ret_data,

    input  logic         dc_wr_req,
    input  logic [2:0]   dc_wr_type,
    input  logic [31:0]  dc_wr_addr,
    input  logic [3:0]   dc_wr_wstrb,
    input  logic [127:0] dc_wr_data,
    output logic         dc_wr_rdy,

    output logic         mem_rd_req,
    output logic [2:0]   mem_rd_type,
    output logic [31:0]  mem_rd_addr,
    input  logic         mem_rd_rdy,
    input  logic         mem_ret_valid,
    input  logic         mem_ret_last,
    input  logic [31:0]  mem_ret_data,

    output logic         mem_wr_valid,
    output logic [31:0]  mem_wr_addr,
    output logic [31:0]  mem_wr_data,
    output logic [3:0]   mem_wr_strb,
    output logic         mem_wr_last,
    input  logic         mem_wr_ready,
    input  logic         mem_wr_done
);

    localparam int         CW        = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [2:0] TYPE_LINE = 3'b100;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RET  = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    // ---------------------------------------------------------------- state
    rd_state_t rd_state_reg, rd_state_next;
    wr_state_t wr_state_reg, wr_state_next;

    logic        rd_owner_reg;      // 1: current burst belongs to dcache
    logic        last_grant_reg;    // 1: dcache was granted most recently
    logic [31:0] rd_addr_reg;
    logic [2:0]  rd_type_reg;

    logic [31:0]               wbuf_addr_reg;
    logic [32*LINE_WORDS-1:0]  wbuf_data_reg;
    logic [3:0]                wbuf_strb_reg;
    logic [CW-1:0]             wbuf_last_idx_reg;
    logic [CW-1:0]             beat_cnt_reg;

    // ------------------------------------------------------- arbitration
    logic grant_ic, grant_dc;
    logic dc_hazard, dc_eligible;

    // A dcache read must not overtake a buffered write to the same line:
    // check both the line already in the buffer and one being accepted now.
    assign dc_hazard =
        ((wr_state_reg != W_IDLE) && (dc_rd_addr[31:4] == wbuf_addr_reg[31:4])) ||
        ((wr_state_reg == W_IDLE) && dc_wr_req && (dc_rd_addr[31:4] == dc_wr_addr[31:4]));
    assign dc_eligible = dc_rd_req && !dc_hazard;

    // -------------------------------------------------- read FSM (comb)
    always_comb begin
        rd_state_next = rd_state_reg;
        grant_ic      = 1'b0;
        grant_dc      = 1'b0;
        mem_rd_req    = 1'b0;
        case (rd_state_reg)
            R_IDLE: begin
                // Grants are combinational handshakes; suppress them while
                // reset is asserted so no request appears accepted.
                if (resetn) begin
                    if (ic_rd_req && dc_eligible) begin
                        if (RR_EN && last_grant_reg) grant_ic = 1'b1;
                        else                         grant_dc = 1'b1;
                    end else if (dc_eligible) begin
                        grant_dc = 1'b1;
                    end else if (ic_rd_req) begin
                        grant_ic = 1'b1;
                    end
                    if (grant_ic || grant_dc) rd_state_next = R_REQ;
                end
            end
            R_REQ: begin
                mem_rd_req = 1'b1;
                if (mem_rd_rdy) rd_state_next = R_RET;
            end
            R_RET: begin
                if (mem_ret_valid && mem_ret_last) rd_state_next = R_IDLE;
            end
            default: rd_state_next = R_IDLE;
        endcase
    end

    assign ic_rd_rdy   = grant_ic;
    assign dc_rd_rdy   = grant_dc;
    assign mem_rd_addr = rd_addr_reg;
    assign mem_rd_type = rd_type_reg;

    // Return beats are only meaningful while a burst is outstanding; stray
    // beats in any other state are dropped here.
    logic ret_fwd;
    assign ret_fwd      = (rd_state_reg == R_RET) && mem_ret_valid;
    assign ic_ret_valid = ret_fwd && !rd_owner_reg;
    assign dc_ret_valid = ret_fwd &&  rd_owner_reg;
    assign ic_ret_last  = {1'b0, ic_ret_valid && mem_ret_last};
    assign dc_ret_last  = {1'b0, dc_ret_valid && mem_ret_last};
    assign ic_ret_data  = mem_ret_data;
    assign dc_ret_data  = mem_ret_data;

    // ------------------------------------------------- write FSM (comb)
    always_comb begin
        wr_state_next = wr_state_reg;
        dc_wr_rdy     = 1'b0;
        mem_wr_valid  = 1'b0;
        case (wr_state_reg)
            W_IDLE: begin
                dc_wr_rdy = 1'b1;
                if (dc_wr_req) wr_state_next = W_DATA;
            end
            W_DATA: begin
                mem_wr_valid = 1'b1;
                if (mem_wr_ready && mem_wr_last) wr_state_next = W_RESP;
            end
            W_RESP: begin
                if (mem_wr_done) wr_state_next = W_IDLE;
            end
            default: wr_state_next = W_IDLE;
        endcase
    end

    // Split the buffered line into beat-sized words for the output mux.
    logic [31:0] wbuf_word [LINE_WORDS];
    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wbuf_word
            assign wbuf_word[gi] = wbuf_data_reg[32*gi +: 32];
        end
    endgenerate

    assign mem_wr_addr = wbuf_addr_reg;
    assign mem_wr_data = wbuf_word[beat_cnt_reg];
    assign mem_wr_strb = wbuf_strb_reg;
    assign mem_wr_last = (wr_state_reg == W_DATA) && (beat_cnt_reg == wbuf_last_idx_reg);

    // ------------------------------------------------ state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_reg <= R_IDLE;
            wr_state_reg <= W_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
            wr_state_reg <= wr_state_next;
        end
    end

    // ------------------------------------------------ read datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_owner_reg   <= 1'b0;
            last_grant_reg <= 1'b0;
            rd_addr_reg    <= '0;
            rd_type_reg    <= '0;
        end else if (grant_ic || grant_dc) begin
            rd_owner_reg   <= grant_dc;
            last_grant_reg <= grant_dc;
            rd_addr_reg    <= grant_dc ? dc_rd_addr : ic_rd_addr;
            rd_type_reg    <= grant_dc ? dc_rd_type : ic_rd_type;
        end
    end

    // ------------------------------------------------ write datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wbuf_addr_reg     <= '0;
            wbuf_data_reg     <= '0;
            wbuf_strb_reg     <= '0;
            wbuf_last_idx_reg <= '0;
            beat_cnt_reg      <= '0;
        end else if ((wr_state_reg == W_IDLE) && dc_wr_req) begin
            wbuf_addr_reg <= dc_wr_addr;
            wbuf_data_reg <= dc_wr_data;
            beat_cnt_reg  <= '0;
            // Anything other than a line write is sent as a single word.
            if (dc_wr_type == TYPE_LINE) begin
                wbuf_strb_reg     <= 4'hf;
                wbuf_last_idx_reg <= CW'(LINE_WORDS - 1);
            end else begin
                wbuf_strb_reg     <= dc_wr_wstrb;
                wbuf_last_idx_reg <= '0;
            end
        end else if ((wr_state_reg == W_DATA) && mem_wr_ready) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
//   Directed stimulus with a scoreboard: expected read requests, return beats
//   and write beats are queued as stimulus is issued; a negedge monitor pops
//   and compares whenever the DUT presents the matching handshake.
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         ic_rd_req = 0;  logic [2:0] ic_rd_type = 0;  logic [31:0] ic_rd_addr = 0;
    logic         ic_rd_rdy, ic_ret_valid;  logic [1:0] ic_ret_last;  logic [31:0] ic_ret_data;
    logic         dc_rd_req = 0;  logic [2:0] dc_rd_type = 0;  logic [31:0] dc_rd_addr = 0;
    logic         dc_rd_rdy, dc_ret_valid;  logic [1:0] dc_ret_last;  logic [31:0] dc_ret_data;
    logic         dc_wr_req = 0;  logic [2:0] dc_wr_type = 0;  logic [31:0] dc_wr_addr = 0;
    logic [3:0]   dc_wr_wstrb = 0; logic [127:0] dc_wr_data = 0;
    logic         dc_wr_rdy;
    logic         mem_rd_req;  logic [2:0] mem_rd_type;  logic [31:0] mem_rd_addr;
    logic         mem_rd_rdy = 0, mem_ret_valid = 0, mem_ret_last = 0;
    logic [31:0]  mem_ret_data = 0;
    logic         mem_wr_valid;  logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]   mem_wr_strb;   logic mem_wr_last;
    logic         mem_wr_ready = 0, mem_wr_done = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.RR_EN(1'b1), .LINE_WORDS(4)) dut (
        .clk(clk), .resetn(resetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
        .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
        .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
        .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
        .dc_ret_data(dc_ret_data),
        .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
        .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
        .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
        .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
        .mem_ret_data(mem_ret_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_strb(mem_wr_strb), .mem_wr_last(mem_wr_last), .mem_wr_ready(mem_wr_ready),
        .mem_wr_done(mem_wr_done)
    );

    typedef struct packed { logic [31:0] data; logic last; } ret_t;
    typedef struct packed { logic [31:0] addr; logic [2:0] typ; } rdreq_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; logic last; } wbeat_t;

    ret_t   ic_q[$];
    ret_t   dc_q[$];
    rdreq_t rd_q[$];
    wbeat_t wr_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] v);
        checks++;
        errors++;
        $display("FAIL %s: actual beat %0h required none", name, v);
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin : monitor
        ret_t   r;
        rdreq_t q;
        wbeat_t w;
        if (mem_rd_req && mem_rd_rdy) begin
            if (rd_q.size() == 0) unexpected("mem_rd_req", mem_rd_addr);
            else begin
                q = rd_q.pop_front();
                chk("mem_rd_addr", mem_rd_addr, q.addr);
                chk("mem_rd_type", mem_rd_type, q.typ);
            end
        end
        if (ic_ret_valid) begin
            if (ic_q.size() == 0) unexpected("ic_ret", ic_ret_data);
            else begin
                r = ic_q.pop_front();
                chk("ic_ret_data", ic_ret_data, r.data);
                chk("ic_ret_last", ic_ret_last, {1'b0, r.last});
            end
        end
        if (dc_ret_valid) begin
            if (dc_q.size() == 0) unexpected("dc_ret", dc_ret_data);
            else begin
                r = dc_q.pop_front();
                chk("dc_ret_data", dc_ret_data, r.data);
                chk("dc_ret_last", dc_ret_last, {1'b0, r.last});
            end
        end
        if (mem_wr_valid && mem_wr_ready) begin
            if (wr_q.size() == 0) unexpected("mem_wr", mem_wr_data);
            else begin
                w = wr_q.pop_front();
                chk("mem_wr_addr", mem_wr_addr, w.addr);
                chk("mem_wr_data", mem_wr_data, w.data);
                chk("mem_wr_strb", mem_wr_strb, w.strb);
                chk("mem_wr_last", mem_wr_last, w.last);
            end
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bridge model for one read burst: accept the request, then return n
    // beats of base*(k+1). Expected beats are queued for the given owner.
    task automatic serve_read(input bit to_dc, input int n, input logic [31:0] base);
        int k;
        k = 0;
        while (!mem_rd_req && k < 20) begin
            tick();
            k++;
        end
        if (!mem_rd_req) begin
            checks++;
            errors++;
            $display("FAIL serve_read_timeout: mem_rd_req actual 0 required 1");
            return;
        end
        mem_rd_rdy = 1'b1;
        tick();
        mem_rd_rdy = 1'b0;
        for (int b = 0; b < n; b++) begin
            ret_t e;
            e.data = base * 32'(b + 1);
            e.last = (b == n - 1);
            if (to_dc) dc_q.push_back(e);
            else       ic_q.push_back(e);
            mem_ret_valid = 1'b1;
            mem_ret_data  = e.data;
            mem_ret_last  = e.last;
            tick();
        end
        mem_ret_valid = 1'b0;
        mem_ret_last  = 1'b0;
        mem_ret_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_dc_wr_rdy", dc_wr_rdy, 1'b1);
        chk("rst_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_mem_wr_valid", mem_wr_valid, 1'b0);

        // Tie after reset: dcache first
        tick();
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c00_0040;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_2000;
        @(negedge clk);
        chk("tie1_dc_rd_rdy", dc_rd_rdy, 1'b1);
        chk("tie1_ic_rd_rdy", ic_rd_rdy, 1'b0);
        rd_q.push_back(rdreq_t'{addr: 32'h0000_2000, typ: 3'b010});
        tick();
        dc_rd_req = 0;
        serve_read(1'b1, 1, 32'h0000_aaaa);

        // Second tie: icache this time
        dc_rd_req = 1; dc_rd_addr = 32'h0000_3000;
        @(negedge clk);
        chk("tie2_ic_rd_rdy", ic_rd_rdy, 1'b1);
        chk("tie2_dc_rd_rdy", dc_rd_rdy, 1'b0);
        rd_q.push_back(rdreq_t'{addr: 32'h1c00_0040, typ: 3'b100});
        tick();
        ic_rd_req = 0;
        serve_read(1'b0, 4, 32'h0000_0011);   // 0x11,0x22,0x33,0x44

        // Pending dcache read granted as soon as the burst ends
        @(negedge clk);
        chk("dc_after_ic_rd_rdy", dc_rd_rdy, 1'b1);
        rd_q.push_back(rdreq_t'{addr: 32'h0000_3000, typ: 3'b010});
        tick();
        dc_rd_req = 0;
        serve_read(1'b1, 1, 32'h0000_0077);

        // Stray return beat while idle is never forwarded
        mem_ret_valid = 1; mem_ret_data = 32'h0000_0bad; mem_ret_last = 1;
        @(negedge clk);
        chk("stray_ic_ret_valid", ic_ret_valid, 1'b0);
        chk("stray_dc_ret_valid", dc_ret_valid, 1'b0);
        tick();
        mem_ret_valid = 0; mem_ret_last = 0;

        // Line write, then a hazarding dcache read plus an icache read
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_1230; dc_wr_wstrb = 4'h0;
        dc_wr_data = 128'h00000004_00000003_00000002_00000001;
        @(negedge clk);
        chk("line_wr_rdy", dc_wr_rdy, 1'b1);
        wr_q.push_back(wbeat_t'{addr: 32'h1230, data: 32'h1, strb: 4'hf, last: 1'b0});
        wr_q.push_back(wbeat_t'{addr: 32'h1230, data: 32'h2, strb: 4'hf, last: 1'b0});
        wr_q.push_back(wbeat_t'{addr: 32'h1230, data: 32'h3, strb: 4'hf, last: 1'b0});
        wr_q.push_back(wbeat_t'{addr: 32'h1230, data: 32'h4, strb: 4'hf, last: 1'b1});
        tick();
        dc_wr_req = 0;
        dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h0000_1234;
        ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h0000_0500;
        @(negedge clk);
        chk("haz_dc_rd_rdy", dc_rd_rdy, 1'b0);
        chk("haz_ic_rd_rdy", ic_rd_rdy, 1'b1);
        chk("busy_dc_wr_rdy", dc_wr_rdy, 1'b0);
        rd_q.push_back(rdreq_t'{addr: 32'h0000_0500, typ: 3'b010});
        tick();
        ic_rd_req = 0;
        serve_read(1'b0, 1, 32'h0000_0099);
        @(negedge clk);
        chk("haz_idle_dc_rd_rdy", dc_rd_rdy, 1'b0);
        tick();
        mem_wr_ready = 1;
        repeat (4) tick();
        mem_wr_ready = 0;
        @(negedge clk);
        chk("resp_dc_wr_rdy", dc_wr_rdy, 1'b0);
        chk("resp_dc_rd_rdy", dc_rd_rdy, 1'b0);
        chk("resp_mem_wr_valid", mem_wr_valid, 1'b0);
        tick();
        mem_wr_done = 1;
        @(negedge clk);
        chk("done_cycle_dc_wr_rdy", dc_wr_rdy, 1'b0);
        tick();
        mem_wr_done = 0;
        @(negedge clk);
        chk("after_done_dc_wr_rdy", dc_wr_rdy, 1'b1);
        chk("haz_release_dc_rd_rdy", dc_rd_rdy, 1'b1);
        rd_q.push_back(rdreq_t'{addr: 32'h0000_1234, typ: 3'b010});
        tick();
        dc_rd_req = 0;
        serve_read(1'b1, 1, 32'h0000_5555);

        // Word write: one beat, caller strobe kept
        dc_wr_req = 1; dc_wr_type = 3'b010; dc_wr_addr = 32'h0000_0080; dc_wr_wstrb = 4'b0011;
        dc_wr_data = 128'hffffffff_eeeeeeee_dddddddd_deadbeef;
        wr_q.push_back(wbeat_t'{addr: 32'h80, data: 32'hdeadbeef, strb: 4'b0011, last: 1'b1});
        tick();
        dc_wr_req = 0;
        mem_wr_ready = 1;
        tick();
        mem_wr_ready = 0;
        @(negedge clk);
        chk("word_single_beat_valid", mem_wr_valid, 1'b0);
        tick();
        mem_wr_done = 1;
        tick();
        mem_wr_done = 0;

        // Reset in the middle of a read burst and a write burst
        ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c00_0080;
        dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h0000_0040;
        @(negedge clk);
        chk("pre_rst_ic_rd_rdy", ic_rd_rdy, 1'b1);
        rd_q.push_back(rdreq_t'{addr: 32'h1c00_0080, typ: 3'b100});
        tick();
        dc_wr_req = 0;
        mem_rd_rdy = 1;
        tick();
        mem_rd_rdy = 0;
        ic_q.push_back(ret_t'{data: 32'h0000_00ab, last: 1'b0});
        mem_ret_valid = 1; mem_ret_data = 32'h0000_00ab; mem_ret_last = 0;
        tick();
        mem_ret_data = 32'h0000_00cd;
        #2 resetn = 0;
        #1;
        chk("rst_mid_ic_ret_valid", ic_ret_valid, 1'b0);
        chk("rst_mid_mem_rd_req", mem_rd_req, 1'b0);
        chk("rst_mid_mem_wr_valid", mem_wr_valid, 1'b0);
        chk("rst_mid_dc_wr_rdy", dc_wr_rdy, 1'b1);
        chk("rst_mid_ic_rd_rdy", ic_rd_rdy, 1'b0);
        mem_ret_valid = 0;
        tick();
        tick();
        resetn = 1;
        @(negedge clk);
        chk("post_rst_ic_rd_rdy", ic_rd_rdy, 1'b1);
        chk("post_rst_mem_wr_valid", mem_wr_valid, 1'b0);
        rd_q.push_back(rdreq_t'{addr: 32'h1c00_0080, typ: 3'b100});
        tick();
        ic_rd_req = 0;
        serve_read(1'b0, 4, 32'h0000_1000);

        repeat (3) tick();
        chk("end_rd_q_empty", rd_q.size(), 0);
        chk("end_ic_q_empty", ic_q.size(), 0);
        chk("end_dc_q_empty", dc_q.size(), 0);
        chk("end_wr_q_empty", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
